// File: rtl/control_unit.sv
// Multi-cycle instruction controller: decodes mv/mvi/add/sub from a latched IR
// into bus-select and register-enable strobes over states T0..T3.
module control_unit (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Run,
  input  logic [15:0] DIN,
  output logic [0:7]  Rout,
  output logic        Gout,
  output logic        DINout,
  output logic [0:7]  Rin,
  output logic        IRin,
  output logic        Ain,
  output logic        Gin,
  output logic        AddSub,
  output logic        Done,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} state_t;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  state_t     state, state_next;
  logic [8:0] ir;
  logic [2:0] opcode, x, y;
  logic       is_arith;

  assign opcode    = ir[8:6];
  assign x         = ir[5:3];
  assign y         = ir[2:0];
  assign is_arith  = (opcode == OP_ADD) || (opcode == OP_SUB);
  assign dbg_state = state;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= T0;
      ir    <= '0;
    end else begin
      state <= state_next;
      if (IRin) ir <= DIN[15:7];
    end
  end

  // Handshake: Run is a request accepted only while in T0 (IRin=1 acknowledges
  // it); Done pulses on the final cycle of the instruction, after which the
  // controller is back in T0 and ready for the next Run.
  always_comb begin
    Rout       = '0;
    Rin        = '0;
    Gout       = 1'b0;
    DINout     = 1'b0;
    IRin       = 1'b0;
    Ain        = 1'b0;
    Gin        = 1'b0;
    AddSub     = 1'b0;
    Done       = 1'b0;
    state_next = T0;
    if (!Reset) begin
      case (state)
        T0: begin
          IRin       = Run;
          state_next = Run ? T1 : T0;
        end
        T1: begin
          case (opcode)
            OP_MV: begin
              Rout[y] = 1'b1;
              Rin[x]  = 1'b1;
              Done    = 1'b1;
            end
            OP_MVI: begin
              DINout = 1'b1;
              Rin[x] = 1'b1;
              Done   = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              Rout[x]    = 1'b1;
              Ain        = 1'b1;
              state_next = T2;
            end
            default: Done = 1'b1;
          endcase
        end
        // T2/T3 are only entered for add/sub; any other IR here falls back to T0 silently.
        T2: begin
          if (is_arith) begin
            Rout[y]    = 1'b1;
            Gin        = 1'b1;
            AddSub     = (opcode == OP_SUB);
            state_next = T3;
          end
        end
        T3: begin
          if (is_arith) begin
            Gout   = 1'b1;
            Rin[x] = 1'b1;
            Done   = 1'b1;
          end
        end
        default: state_next = T0;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed vector table plus a random instruction stream for control_unit.
module tb_control_unit;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Run = 1'b0;
  logic [15:0] DIN = '0;
  logic [0:7]  Rout, Rin;
  logic        Gout, DINout, IRin, Ain, Gin, AddSub, Done;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  control_unit dut (
    .Clock(Clock), .Reset(Reset), .Run(Run), .DIN(DIN),
    .Rout(Rout), .Gout(Gout), .DINout(DINout), .Rin(Rin), .IRin(IRin),
    .Ain(Ain), .Gin(Gin), .AddSub(AddSub), .Done(Done), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 Clock = ~Clock;

  // flg = {Gout, DINout, IRin, Ain, Gin, AddSub, Done}
  typedef struct {
    logic        rst;
    logic        run;
    logic [15:0] din;
    logic [7:0]  rout;
    logic [7:0]  rin;
    logic [6:0]  flg;
    logic [1:0]  st;
  } vec_t;

  localparam int NVEC = 28;
  vec_t vecs[NVEC];

  function automatic vec_t mk(logic rst, logic run, logic [15:0] din, logic [7:0] rout,
                              logic [7:0] rin, logic [6:0] flg, logic [1:0] st);
    vec_t v;
    v.rst = rst; v.run = run; v.din = din; v.rout = rout; v.rin = rin; v.flg = flg; v.st = st;
    return v;
  endfunction

  function automatic logic [24:0] actual();
    return {Rout, Rin, Gout, DINout, IRin, Ain, Gin, AddSub, Done, dbg_state};
  endfunction

  // scoreboard compare
  task automatic chk(input string name, input logic [24:0] act, input logic [24:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got rout=%b rin=%b flg=%b st=%0d, expected rout=%b rin=%b flg=%b st=%0d",
               name, act[24:17], act[16:9], act[8:2], act[1:0],
               exp[24:17], exp[16:9], exp[8:2], exp[1:0]);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // driver: apply inputs mid-cycle, sample 1 time unit later
  task automatic drive(input logic rst, input logic run, input logic [15:0] din);
    @(negedge Clock);
    Reset = rst;
    Run   = run;
    DIN   = din;
    #1;
  endtask

  initial begin
    int m_state;
    logic [2:0] m_op;
    int starts, dones;
    logic [15:0] rdin;
    logic rrun;

    vecs[0]  = mk(0, 1, 16'h0A00, 8'b00000000, 8'b00000000, 7'b0010000, 2'd0); // mv R2,R4 start
    vecs[1]  = mk(0, 0, 16'h0000, 8'b00001000, 8'b00100000, 7'b0000001, 2'd1);
    vecs[2]  = mk(0, 0, 16'h0000, 8'b00000000, 8'b00000000, 7'b0000000, 2'd0);
    vecs[3]  = mk(0, 1, 16'h3400, 8'b00000000, 8'b00000000, 7'b0010000, 2'd0); // mvi R5
    vecs[4]  = mk(0, 0, 16'h1234, 8'b00000000, 8'b00000100, 7'b0100001, 2'd1);
    vecs[5]  = mk(0, 1, 16'h6700, 8'b00000000, 8'b00000000, 7'b0010000, 2'd0); // sub R1,R6
    vecs[6]  = mk(0, 1, 16'h0A00, 8'b01000000, 8'b00000000, 7'b0001000, 2'd1); // Run ignored
    vecs[7]  = mk(0, 0, 16'h0000, 8'b00000010, 8'b00000000, 7'b0000110, 2'd2);
    vecs[8]  = mk(0, 0, 16'h0000, 8'b00000000, 8'b01000000, 7'b1000001, 2'd3);
    vecs[9]  = mk(0, 0, 16'h0000, 8'b00000000, 8'b00000000, 7'b0000000, 2'd0);
    vecs[10] = mk(0, 1, 16'h4380, 8'b00000000, 8'b00000000, 7'b0010000, 2'd0); // add R0,R7
    vecs[11] = mk(0, 0, 16'h0000, 8'b10000000, 8'b00000000, 7'b0001000, 2'd1);
    vecs[12] = mk(1, 1, 16'h0000, 8'b00000000, 8'b00000000, 7'b0000000, 2'd2); // reset in T2
    vecs[13] = mk(0, 0, 16'h0000, 8'b00000000, 8'b00000000, 7'b0000000, 2'd0);
    vecs[14] = mk(0, 1, 16'h4900, 8'b00000000, 8'b00000000, 7'b0010000, 2'd0); // add R2,R2
    vecs[15] = mk(0, 0, 16'h0000, 8'b00100000, 8'b00000000, 7'b0001000, 2'd1);
    vecs[16] = mk(0, 0, 16'h0000, 8'b00100000, 8'b00000000, 7'b0000100, 2'd2);
    vecs[17] = mk(0, 0, 16'h0000, 8'b00000000, 8'b00100000, 7'b1000001, 2'd3);
    vecs[18] = mk(0, 1, 16'hE000, 8'b00000000, 8'b00000000, 7'b0010000, 2'd0); // illegal
    vecs[19] = mk(0, 0, 16'h0000, 8'b00000000, 8'b00000000, 7'b0000001, 2'd1);
    vecs[20] = mk(0, 0, 16'h0000, 8'b00000000, 8'b00000000, 7'b0000000, 2'd0);
    vecs[21] = mk(0, 1, 16'h0D80, 8'b00000000, 8'b00000000, 7'b0010000, 2'd0); // mv R3,R3
    vecs[22] = mk(0, 0, 16'h0000, 8'b00010000, 8'b00010000, 7'b0000001, 2'd1);
    vecs[23] = mk(1, 1, 16'h0A00, 8'b00000000, 8'b00000000, 7'b0000000, 2'd0); // reset beats Run
    vecs[24] = mk(0, 0, 16'h0000, 8'b00000000, 8'b00000000, 7'b0000000, 2'd0);
    vecs[25] = mk(0, 1, 16'h2000, 8'b00000000, 8'b00000000, 7'b0010000, 2'd0); // mvi R0
    vecs[26] = mk(1, 0, 16'h5555, 8'b00000000, 8'b00000000, 7'b0000000, 2'd1); // reset in T1
    vecs[27] = mk(0, 0, 16'h0000, 8'b00000000, 8'b00000000, 7'b0000000, 2'd0);

    // reset preamble: outputs must be zero while Reset is high, even with Run=1
    drive(1, 1, 16'h0A00);
    chk("reset_outputs", {actual()} & 25'h1FFFFFC, 25'h0);
    drive(1, 1, 16'h0A00);
    chk("reset_state", actual(), 25'h0);

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].rst, vecs[i].run, vecs[i].din);
      chk($sformatf("vec%0d", i), actual(),
          {vecs[i].rout, vecs[i].rin, vecs[i].flg, vecs[i].st});
    end

    // random stream: reference sequencer tracks where Done must fire
    m_state = 0;
    m_op    = 3'b000;
    starts  = 0;
    dones   = 0;
    for (int c = 0; c < 400; c++) begin
      rrun = (c < 390) ? 1'($urandom_range(0, 1)) : 1'b0;
      rdin = 16'($urandom());
      drive(0, rrun, rdin);
      chk_bit("bus_exclusive", ($countones({Rout, Gout, DINout}) <= 1), 1'b1);
      chk_bit("rin_onehot0", $onehot0(Rin), 1'b1);
      if (m_state == 0 && !rrun)
        chk("t0_idle", actual(), 25'h0);
      chk_bit("done_timing", Done,
              (m_state == 1 && !(m_op == 3'b010 || m_op == 3'b011)) || m_state == 3);
      if (Done) dones++;
      case (m_state)
        0: if (rrun) begin m_state = 1; m_op = rdin[15:13]; starts++; end
        1: m_state = (m_op == 3'b010 || m_op == 3'b011) ? 2 : 0;
        2: m_state = 3;
        default: m_state = 0;
      endcase
    end
    checks++;
    if (starts != dones) begin
      errors++;
      $display("FAIL done_count: got %0d dones expected %0d", dones, starts);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset; ports Clock and Reset.
REQ-002 Clock  input  1  rising-edge clock for all state.
REQ-003 Reset  input  1  synchronous, active-high; sampled on rising Clock.
REQ-004 Run  input  1  start request, sampled in state T0 only.
REQ-005 DIN  input  16  instruction word; DIN[15:13]=opcode III, DIN[12:10]=XXX, DIN[9:7]=YYY.
REQ-006 Rout  output  [0:7]  one-hot bus-source select; Rout[i]=1 drives Ri onto the bus (R0 = 8'b10000000).
REQ-007 Gout  output  1  drives G onto the bus.
REQ-008 DINout  output  1  drives DIN onto the bus.
REQ-009 Rin  output  [0:7]  register load enables; Rin[i]=1 loads Ri from the bus at the next edge.
REQ-010 IRin  output  1  IR load strobe, for observation.
REQ-011 Ain  output  1  A load enable.
REQ-012 Gin  output  1  G load enable.
REQ-013 AddSub  output  1  ALU op: 0 = add, 1 = sub.
REQ-014 Done  output  1  one-cycle pulse marking the final cycle of an instruction.

Function
REQ-015 SHALL hold a 2-bit state T0..T3 and a 9-bit IR; all outputs are combinational decodes of state, IR and Run.
REQ-016 Opcodes: 000 mv Rx<-Ry; 001 mvi Rx<-DIN; 010 add Rx<-Rx+Ry; 011 sub Rx<-Rx-Ry; 100-111 illegal.
REQ-017 T0: IRin=Run; if Run=1 then IR<=DIN[15:7] and go to T1; else stay in T0 with all other outputs 0.
REQ-018 T1 mv: Rout[Y]=1, Rin[X]=1, Done=1; next T0.
REQ-019 T1 mvi: DINout=1, Rin[X]=1, Done=1; next T0 (immediate is the DIN word present during T1).
REQ-020 T1 add/sub: Rout[X]=1, Ain=1; next T2.
REQ-021 T2 add/sub: Rout[Y]=1, Gin=1, AddSub=(opcode==011); next T3.
REQ-022 T3 add/sub: Gout=1, Rin[X]=1, Done=1; next T0.
REQ-023 T1 illegal opcode: Done=1, all enables and selects 0; next T0; no register written.
REQ-024 Bus exclusivity: in every cycle at most one of {any Rout bit, Gout, DINout} is 1; Rin is 0 or one-hot.
REQ-025 Run is ignored in T1-T3; a new instruction starts only from T0. Back-to-back instructions need Run=1 in the T0 following Done.
REQ-026 X=Y is legal: mv R3,R3 asserts Rout[3] and Rin[3] together; add R2,R2 doubles R2.
REQ-027 Done SHALL be high for exactly one cycle per instruction: latency 2 cycles (mv/mvi/illegal) or 4 cycles (add/sub), counted from the T0 edge that samples Run.
REQ-028 Unreachable state encodings, if any, SHALL return to T0 with outputs 0.

Reset
REQ-029 While Reset=1, all outputs are forced to 0 in the same cycle; at the next edge state<=T0 and IR<=0.
REQ-030 Reset asserted mid-instruction (T1-T3) SHALL abort it: no Done, no Rin pulse in the reset cycle, and T0 after the edge.
REQ-031 Reset takes priority over Run in the same cycle.

Verification
REQ-032 Reset, then Run=1 with DIN=16'h0A00 (mv R2,R4) -> T1: Rout=8'b00001000, Rin=8'b00100000, Done=1; idle T0 next cycle.
REQ-033 mvi R5: DIN=16'h3400 at T0, DIN=16'h1234 at T1 -> T1: DINout=1, Rin[5]=1, Done=1, Rout=0.
REQ-034 sub R1,R6 (DIN=16'h6700) -> T1 Rout[1],Ain; T2 Rout[6],Gin,AddSub=1; T3 Gout,Rin[1],Done; Done 4 cycles after start.
REQ-035 Reset pulsed during T2 of add R0,R7 -> outputs 0 in the reset cycle, T0 next, no Done, no Rin; next Run starts cleanly.
REQ-036 Illegal opcode 16'hE000 -> single Done at T1, Rin=0, Rout=0, Gout=0, DINout=0.
REQ-037 Random instruction stream with Run toggling -> a checker each cycle asserts REQ-024 exclusivity, a single Done per instruction, and no activity in T0 while Run=0.
